// File: rtl/reg_pipeline.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake, bubble
// collapsing, synchronous flush and occupancy count.
module reg_pipeline #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 3,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter bit               CLEAR_DATA = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] uv;
  logic [WIDTH-1:0] ud [DEPTH];

  // A stage is ready when it is empty or everything downstream of it can move.
  always_comb begin
    logic acc;
    acc = out_ready;
    r   = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      acc  = ~v_q[k] | acc;
      r[k] = acc;
    end
  end

  always_comb begin
    uv[0] = in_valid;
    ud[0] = in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      uv[k] = v_q[k-1];
      ud[k] = d_q[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      v_d[k] = v_q[k];
      d_d[k] = d_q[k];
      if (flush) begin
        v_d[k] = 1'b0;
        if (CLEAR_DATA) d_d[k] = RST_VAL;
      end else if (r[k]) begin
        v_d[k] = uv[k];
        // Data only moves with a valid word so an emptied stage keeps its value.
        if (uv[k]) d_d[k] = ud[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) d_q[k] <= RST_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occupancy = occupancy + OccW'(v_q[k]);
  end

  assign in_ready  = r[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed and randomised checks of reg_pipeline at DEPTH 1, 3 and 4 sharing one stimulus.
module tb_reg_pipeline;

  logic       clk = 1'b0;
  bit         clk_en = 1'b1;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic       ir3, ov3, ir1, ov1, ir4, ov4;
  logic [7:0] od3, od1, od4;
  logic [1:0] oc3;
  logic [0:0] oc1;
  logic [2:0] oc4;

  int n_cmp = 0;
  int n_fail = 0;

  reg_pipeline #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hC3), .CLEAR_DATA(1'b0)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .occupancy(oc3)
  );

  reg_pipeline #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'hE1), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1)
  );

  reg_pipeline #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h3C), .CLEAR_DATA(1'b1)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .occupancy(oc4)
  );

  initial forever #5 if (clk_en) clk = ~clk;

  logic       ov_a [3];
  logic       ir_a [3];
  logic [7:0] od_a [3];
  int         oc_a [3];

  always_comb begin
    ov_a[0] = ov1; ir_a[0] = ir1; od_a[0] = od1; oc_a[0] = int'(oc1);
    ov_a[1] = ov3; ir_a[1] = ir3; od_a[1] = od3; oc_a[1] = int'(oc3);
    ov_a[2] = ov4; ir_a[2] = ir4; od_a[2] = od4; oc_a[2] = int'(oc4);
  end

  task automatic test_reset();
    // Power-on reset, held across clock edges.
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL por_out_valid got %b want 0", ov3); end
    n_cmp++; if (od3 !== 8'hC3) begin n_fail++; $display("FAIL por_out_data got %h want c3", od3); end
    n_cmp++; if (od4 !== 8'h3C) begin n_fail++; $display("FAIL por_out_data4 got %h want 3c", od4); end
    n_cmp++; if (oc3 !== 2'd0) begin n_fail++; $display("FAIL por_occupancy got %0d want 0", oc3); end
    rst = 1'b0;
    // Load a word, then reset asynchronously with the clock stopped.
    @(negedge clk); in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (oc3 !== 2'd1) begin n_fail++; $display("FAIL pre_rst_occupancy got %0d want 1", oc3); end
    clk_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b want 0", ov3); end
    n_cmp++; if (od3 !== 8'hC3) begin n_fail++; $display("FAIL arst_out_data got %h want c3", od3); end
    n_cmp++; if (oc3 !== 2'd0) begin n_fail++; $display("FAIL arst_occupancy got %0d want 0", oc3); end
    n_cmp++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got %b want 1", ir3); end
    #3 rst = 1'b0;
    #2 clk_en = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      logic exp_v;
      @(negedge clk);
      in_valid = (c < 10);
      in_data  = 8'(c + 1);
      #1;
      exp_v = (c >= 3) && (c < 13);
      if (c < 10) begin
        n_cmp++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, ir3); end
      end
      n_cmp++; if (ov3 !== exp_v) begin n_fail++; $display("FAIL stream_out_valid c=%0d got %b want %b", c, ov3, exp_v); end
      if (exp_v) begin
        n_cmp++; if (od3 !== 8'(c - 2)) begin n_fail++; $display("FAIL stream_out_data c=%0d got %h want %h", c, od3, 8'(c - 2)); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic       iv  [9] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    logic [7:0] dd  [9] = '{8'hA1, 0, 8'hA2, 8'hA3, 0, 0, 0, 0, 0};
    logic       orr [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    int         occ [9] = '{0, 1, 1, 2, 3, 3, 2, 1, 0};
    logic       irx [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    logic       ovx [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    logic [7:0] odx [9] = '{0, 0, 0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 0};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      in_valid = iv[c]; in_data = dd[c]; out_ready = orr[c];
      #1;
      n_cmp++; if (int'(oc3) !== occ[c]) begin n_fail++; $display("FAIL bp_occupancy c=%0d got %0d want %0d", c, oc3, occ[c]); end
      n_cmp++; if (ir3 !== irx[c]) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, ir3, irx[c]); end
      n_cmp++; if (ov3 !== ovx[c]) begin n_fail++; $display("FAIL bp_out_valid c=%0d got %b want %b", c, ov3, ovx[c]); end
      if (ovx[c]) begin
        n_cmp++; if (od3 !== odx[c]) begin n_fail++; $display("FAIL bp_out_data c=%0d got %h want %h", c, od3, odx[c]); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_in_out();
    logic       iv  [9] = '{1, 1, 1, 0, 1, 0, 0, 0, 0};
    logic [7:0] dd  [9] = '{8'hB1, 8'hB2, 8'hB3, 0, 8'h55, 0, 0, 0, 0};
    logic       orr [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    int         occ [9] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
    logic       irx [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic       ovx [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    logic [7:0] odx [9] = '{0, 0, 0, 8'hB1, 8'hB1, 8'hB2, 8'hB3, 8'h55, 0};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      in_valid = iv[c]; in_data = dd[c]; out_ready = orr[c];
      #1;
      n_cmp++; if (int'(oc3) !== occ[c]) begin n_fail++; $display("FAIL full_occupancy c=%0d got %0d want %0d", c, oc3, occ[c]); end
      n_cmp++; if (ir3 !== irx[c]) begin n_fail++; $display("FAIL full_in_ready c=%0d got %b want %b", c, ir3, irx[c]); end
      n_cmp++; if (ov3 !== ovx[c]) begin n_fail++; $display("FAIL full_out_valid c=%0d got %b want %b", c, ov3, ovx[c]); end
      if (ovx[c]) begin
        n_cmp++; if (od3 !== odx[c]) begin n_fail++; $display("FAIL full_out_data c=%0d got %h want %h", c, od3, odx[c]); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk); in_valid = 1'b1; in_data = 8'hC1; out_ready = 1'b0;
    @(negedge clk); in_data = 8'hC2;
    @(negedge clk); in_data = 8'h77; flush = 1'b1;
    #1;
    n_cmp++; if (oc3 !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occupancy got %0d want 2", oc3); end
    @(negedge clk); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (oc3 !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy got %0d want 0", oc3); end
    n_cmp++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", ov3); end
    n_cmp++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", ir3); end
    n_cmp++; if (od3 !== 8'h55) begin n_fail++; $display("FAIL flush_hold_data got %h want 55", od3); end
    n_cmp++; if (od4 !== 8'h3C) begin n_fail++; $display("FAIL flush_clear_data4 got %h want 3c", od4); end
    n_cmp++; if (od1 !== 8'hE1) begin n_fail++; $display("FAIL flush_clear_data1 got %h want e1", od1); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL flush_discard c=%0d got %b want 0", c, ov3); end
    end
  endtask

  task automatic test_random();
    logic [7:0] sb [3][$];
    int         cnt [3] = '{0, 0, 0};
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (oc_a[i] !== cnt[i]) begin
          n_fail++; $display("FAIL rand_occupancy inst=%0d c=%0d got %0d want %0d", i, c, oc_a[i], cnt[i]);
        end
        if (ov_a[i] && out_ready) begin
          logic [7:0] exp_d;
          exp_d = (sb[i].size() > 0) ? sb[i].pop_front() : 8'hxx;
          n_cmp++;
          if (od_a[i] !== exp_d) begin
            n_fail++; $display("FAIL rand_out_data inst=%0d c=%0d got %h want %h", i, c, od_a[i], exp_d);
          end
          cnt[i]--;
        end
        if (in_valid && ir_a[i]) begin
          sb[i].push_back(in_data);
          cnt[i]++;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_in_out();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
